// File: rtl/dot_product_result_collector.sv
// dot_product_result_collector
// Collects the serial result stream of fp_dot_product into NUM_RESULTS-word
// vectors. The source cannot be stalled, so the block keeps one fill buffer
// and one output buffer. The output buffer is offered downstream with a
// valid/ready handshake. If a vector completes while the output buffer is
// still held, that vector is dropped and a sticky overflow flag is raised.
// Words are treated as opaque bit patterns.

module dot_product_result_collector #(
  parameter int WIDTH       = 32,
  parameter int NUM_RESULTS = 8,
  parameter int CNT_W       = $clog2(NUM_RESULTS + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [WIDTH-1:0]             in_data,
  input  logic                         in_valid,
  input  logic                         flush,
  output logic [WIDTH*NUM_RESULTS-1:0] vec_out,
  output logic                         vec_valid,
  input  logic                         vec_ready,
  output logic [CNT_W-1:0]             fill_count,
  output logic                         overflow,
  output logic                         busy
);

  // Slot index that receives the final word of a vector.
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(NUM_RESULTS - 1);

  // Fill buffer. The last slot is never read back, because the final word
  // goes straight from in_data into the completed vector. The slot is kept
  // so that the array indexing stays uniform.
  logic [WIDTH-1:0]             fill_mem [NUM_RESULTS];

  logic                         accept;     // word is taken into the fill buffer
  logic                         fill_done;  // accepted word completes a vector
  logic                         out_free;   // output buffer can take a vector this edge
  logic                         transfer;   // completed vector moves to the output buffer
  logic                         drop;       // completed vector is lost (overflow)
  logic [WIDTH*NUM_RESULTS-1:0] done_vec;   // completed vector, including the last word

  // Handshake and fill decode; flush always wins over an incoming word.
  always_comb begin
    // NOTE: every combinational output gets a value on every path, so no latch is inferred.
    accept    = in_valid && !flush;
    fill_done = accept && (fill_count == LAST_SLOT);
    out_free  = !vec_valid || vec_ready;
    transfer  = fill_done && out_free;
    drop      = fill_done && !out_free;
  end

  // Build the completed vector: stored slots, then the word arriving now in the top slot.
  always_comb begin
    done_vec = '0;
    for (int k = 0; k < NUM_RESULTS - 1; k++) begin
      done_vec[k*WIDTH +: WIDTH] = fill_mem[k];
    end
    done_vec[(NUM_RESULTS-1)*WIDTH +: WIDTH] = in_data;
  end

  // Fill counter: advance on each accepted word, wrap on completion, clear on flush.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
    if (!rst) begin
      fill_count <= '0;
    end else if (flush) begin
      fill_count <= '0;
    end else if (accept) begin
      if (fill_count == LAST_SLOT) begin
        fill_count <= '0;
      end else begin
        fill_count <= fill_count + CNT_W'(1);
      end
    end
  end

  // Fill buffer write: the accepted word goes into the slot addressed by fill_count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: this storage array is deliberately reset, because reset must leave no stale words behind.
      for (int k = 0; k < NUM_RESULTS; k++) begin
        fill_mem[k] <= '0;
      end
    end else if (accept) begin
      for (int k = 0; k < NUM_RESULTS; k++) begin
        if (fill_count == CNT_W'(k)) begin
          fill_mem[k] <= in_data;
        end
      end
    end
  end

  // Output buffer: load on transfer, release on consume, otherwise hold.
  always_ff @(posedge clk) begin
    if (!rst) begin
      vec_out   <= '0;
      vec_valid <= 1'b0;
    end else if (transfer) begin
      vec_out   <= done_vec;
      vec_valid <= 1'b1;
    end else if (vec_valid && vec_ready) begin
      vec_valid <= 1'b0;
    end
  end

  // Sticky overflow: set when a completed vector is dropped, cleared by flush.
  always_ff @(posedge clk) begin
    if (!rst) begin
      overflow <= 1'b0;
    end else if (flush) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end
  end

  // Activity indicator derived only from registered state.
  always_comb begin
    busy = (fill_count != '0) || vec_valid;
  end

endmodule

// File: tb/tb_dot_product_result_collector.sv
// Testbench for dot_product_result_collector (WIDTH=32, NUM_RESULTS=8).
// A queue-based reference model predicts every output after every clock edge.
// Directed table vectors and hand-written sequences cover the corner cases.
// A long random run follows them.

module tb_dot_product_result_collector;

  localparam int W  = 32;
  localparam int NR = 8;
  localparam int CW = $clog2(NR + 1);
  localparam int VW = W * NR;

  logic          clk;
  logic          rst;
  logic [W-1:0]  in_data;
  logic          in_valid;
  logic          flush;
  logic [VW-1:0] vec_out;
  logic          vec_valid;
  logic          vec_ready;
  logic [CW-1:0] fill_count;
  logic          overflow;
  logic          busy;

  dot_product_result_collector #(.WIDTH(W), .NUM_RESULTS(NR)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .flush      (flush),
    .vec_out    (vec_out),
    .vec_valid  (vec_valid),
    .vec_ready  (vec_ready),
    .fill_count (fill_count),
    .overflow   (overflow),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // Single-precision encodings of 1.0 .. 16.0.
  logic [W-1:0] fl [1:16];

  // Reference model state.
  logic [W-1:0]  m_fill [$];
  logic [VW-1:0] m_out;
  bit            m_valid;
  bit            m_ovf;

  task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [W-1:0] d, input logic f, input logic r);
    in_valid  = v;
    in_data   = d;
    flush     = f;
    vec_ready = r;
  endtask

  // Advance the model on the current inputs, clock the DUT, then compare every output.
  task automatic tick();
    logic [VW-1:0] nv;
    bit loaded;
    bit consumed;
    nv     = '0;
    loaded = 0;
    if (!rst) begin
      m_fill.delete();
      m_out   = '0;
      m_valid = 0;
      m_ovf   = 0;
    end else begin
      consumed = m_valid && vec_ready;
      if (flush) begin
        m_fill.delete();
        m_ovf = 0;
      end else if (in_valid) begin
        m_fill.push_back(in_data);
        if (m_fill.size() == NR) begin
          for (int k = 0; k < NR; k++) nv[k*W +: W] = m_fill[k];
          m_fill.delete();
          if (!m_valid || vec_ready) begin
            m_out  = nv;
            loaded = 1;
          end else begin
            m_ovf = 1;
          end
        end
      end
      if (loaded) m_valid = 1;
      else if (consumed) m_valid = 0;
    end
    @(posedge clk);
    #1;
    cyc++;
    check("model_vec_out",    vec_out, m_out);
    check("model_vec_valid",  VW'(vec_valid), VW'(m_valid));
    check("model_fill_count", VW'(fill_count), VW'(m_fill.size()));
    check("model_overflow",   VW'(overflow), VW'(m_ovf));
    check("model_busy",       VW'(busy), VW'((m_fill.size() != 0) || m_valid));
  endtask

  // Send words lo..hi (as floats) on consecutive cycles with the given ready level.
  task automatic stream(input int lo, input int hi, input logic r);
    for (int i = lo; i <= hi; i++) begin
      drive(1'b1, fl[i], 1'b0, r);
      tick();
    end
  endtask

  function automatic logic [VW-1:0] packed_floats(input int first);
    logic [VW-1:0] v;
    v = '0;
    for (int k = 0; k < NR; k++) v[k*W +: W] = fl[first + k];
    return v;
  endfunction

  typedef struct {
    logic          v;
    logic [W-1:0]  d;
    logic          f;
    logic          r;
    logic          exp_valid;
    logic [CW-1:0] exp_cnt;
    logic          exp_ovf;
    logic          chk_vec;   // also check slots 0 and 7 against 1.0 / 8.0
  } vec_t;

  vec_t tbl [$];

  initial begin
    logic [VW-1:0] first_vec;
    int rise_cyc [$];
    logic prev_valid;

    fl[1]  = 32'h3F800000; fl[2]  = 32'h40000000; fl[3]  = 32'h40400000; fl[4]  = 32'h40800000;
    fl[5]  = 32'h40A00000; fl[6]  = 32'h40C00000; fl[7]  = 32'h40E00000; fl[8]  = 32'h41000000;
    fl[9]  = 32'h41100000; fl[10] = 32'h41200000; fl[11] = 32'h41300000; fl[12] = 32'h41400000;
    fl[13] = 32'h41500000; fl[14] = 32'h41600000; fl[15] = 32'h41700000; fl[16] = 32'h41800000;

    // Basic capture: 8 consecutive words, then one idle cycle.
    for (int i = 1; i <= 8; i++)
      tbl.push_back('{v:1'b1, d:fl[i], f:1'b0, r:1'b1, exp_valid:(i == 8), exp_cnt:CW'(i % 8), exp_ovf:1'b0, chk_vec:(i == 8)});
    tbl.push_back('{v:1'b0, d:'0, f:1'b0, r:1'b1, exp_valid:1'b0, exp_cnt:'0, exp_ovf:1'b0, chk_vec:1'b0});
    // Gapped input: 4 words, 3 idle cycles, 4 words, then one idle cycle.
    for (int i = 1; i <= 4; i++)
      tbl.push_back('{v:1'b1, d:fl[i], f:1'b0, r:1'b1, exp_valid:1'b0, exp_cnt:CW'(i), exp_ovf:1'b0, chk_vec:1'b0});
    for (int i = 0; i < 3; i++)
      tbl.push_back('{v:1'b0, d:32'hDEADBEEF, f:1'b0, r:1'b1, exp_valid:1'b0, exp_cnt:CW'(4), exp_ovf:1'b0, chk_vec:1'b0});
    for (int i = 5; i <= 8; i++)
      tbl.push_back('{v:1'b1, d:fl[i], f:1'b0, r:1'b1, exp_valid:(i == 8), exp_cnt:CW'(i % 8), exp_ovf:1'b0, chk_vec:(i == 8)});
    tbl.push_back('{v:1'b0, d:'0, f:1'b0, r:1'b1, exp_valid:1'b0, exp_cnt:'0, exp_ovf:1'b0, chk_vec:1'b0});

    // Reset state.
    rst = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    tick();
    tick();
    check("reset_vec_valid",  VW'(vec_valid), '0);
    check("reset_fill_count", VW'(fill_count), '0);
    check("reset_overflow",   VW'(overflow), '0);
    check("reset_busy",       VW'(busy), '0);
    check("reset_vec_out",    vec_out, '0);
    rst = 1'b1;
    tick();

    // Table-driven vectors.
    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].f, tbl[i].r);
      tick();
      check($sformatf("tbl%0d_vec_valid", i),  VW'(vec_valid), VW'(tbl[i].exp_valid));
      check($sformatf("tbl%0d_fill_count", i), VW'(fill_count), VW'(tbl[i].exp_cnt));
      check($sformatf("tbl%0d_overflow", i),   VW'(overflow), VW'(tbl[i].exp_ovf));
      if (tbl[i].chk_vec) begin
        check($sformatf("tbl%0d_slot0", i), VW'(vec_out[31:0]), VW'(32'h3F800000));
        check($sformatf("tbl%0d_slot7", i), VW'(vec_out[255:224]), VW'(32'h41000000));
      end
    end

    // Backpressure and overflow: 16 words with vec_ready low.
    first_vec = packed_floats(1);
    stream(1, 8, 1'b0);
    check("bp_first_valid", VW'(vec_valid), VW'(1));
    stream(9, 15, 1'b0);
    check("bp_hold_vec", vec_out, first_vec);
    check("bp_no_ovf_yet", VW'(overflow), '0);
    stream(16, 16, 1'b0);
    check("bp_overflow_set", VW'(overflow), VW'(1));
    check("bp_hold_after_drop", vec_out, first_vec);
    check("bp_count_wrapped", VW'(fill_count), '0);
    drive(1'b0, '0, 1'b0, 1'b1);
    tick();
    check("bp_consumed", VW'(vec_valid), '0);
    check("bp_vec_at_handshake", vec_out, first_vec);
    check("bp_overflow_sticky", VW'(overflow), VW'(1));
    drive(1'b0, '0, 1'b1, 1'b1);
    tick();
    check("flush_clears_ovf", VW'(overflow), '0);

    // Back-to-back with consume: two valid pulses exactly 8 cycles apart.
    drive(1'b0, '0, 1'b0, 1'b1);
    tick();
    prev_valid = vec_valid;
    for (int i = 1; i <= 16; i++) begin
      drive(1'b1, fl[i], 1'b0, 1'b1);
      tick();
      if (vec_valid && !prev_valid) rise_cyc.push_back(cyc);
      prev_valid = vec_valid;
      if (i == 16) check("b2b_second_vec", vec_out, packed_floats(9));
    end
    check("b2b_pulse_count", VW'(rise_cyc.size()), VW'(2));
    if (rise_cyc.size() == 2) check("b2b_spacing", VW'(rise_cyc[1] - rise_cyc[0]), VW'(8));
    check("b2b_no_ovf", VW'(overflow), '0);

    // Simultaneous consume and transfer: vec_valid stays high, no bubble.
    drive(1'b0, '0, 1'b0, 1'b1);
    tick();
    stream(1, 8, 1'b0);
    stream(9, 15, 1'b0);
    stream(16, 16, 1'b1);
    check("swap_valid_kept", VW'(vec_valid), VW'(1));
    check("swap_new_vec", vec_out, packed_floats(9));
    check("swap_no_ovf", VW'(overflow), '0);
    drive(1'b0, '0, 1'b0, 1'b1);
    tick();

    // Flush mid-fill: the word presented with flush is discarded.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'hAAAA0000 + W'(i), 1'b0, 1'b1);
      tick();
    end
    drive(1'b1, 32'h40400000, 1'b1, 1'b1);
    tick();
    check("flush_count_zero", VW'(fill_count), '0);
    stream(1, 8, 1'b1);
    check("flush_refill_valid", VW'(vec_valid), VW'(1));
    check("flush_refill_slot0", VW'(vec_out[31:0]), VW'(32'h3F800000));

    // Reset mid-operation with fill_count=5 and vec_valid=1.
    drive(1'b0, '0, 1'b0, 1'b1);
    tick();
    stream(1, 8, 1'b0);
    stream(1, 5, 1'b0);
    check("rst_pre_count", VW'(fill_count), VW'(5));
    check("rst_pre_valid", VW'(vec_valid), VW'(1));
    rst = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    tick();
    check("rst_mid_vec_out", vec_out, '0);
    check("rst_mid_valid", VW'(vec_valid), '0);
    check("rst_mid_count", VW'(fill_count), '0);
    check("rst_mid_busy", VW'(busy), '0);
    rst = 1'b1;
    stream(1, 8, 1'b1);
    check("rst_fresh_vec", vec_out, packed_floats(1));

    // Random traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 399) != 0);
      drive(($urandom_range(0, 9) < 7), $urandom, ($urandom_range(0, 39) == 0), $urandom_range(0, 1));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
